// File: rtl/p_d_pkg.sv
// Shared types, opcode constants and the opcode-group classifier for the P-D pipe.
package p_d_pkg;

    // Instruction group identifier carried on the grp output.
    typedef enum logic [3:0] {
        GRP_NONE = 4'd0,
        GRP_NA   = 4'd1,
        GRP_KA1  = 4'd2,
        GRP_JS   = 4'd3,
        GRP_KA2  = 4'd4,
        GRP_C    = 4'd5,
        GRP_S    = 4'd6,
        GRP_J    = 4'd7,
        GRP_L    = 4'd8,
        GRP_G    = 4'd9,
        GRP_BN   = 4'd10
    } grp_t;

    // Assembly state of the instruction currently being built.
    typedef enum logic [1:0] {
        DEC_IDLE = 2'd0,
        DEC_ARG  = 2'd1,
        DEC_OUT  = 2'd2
    } fsm_t;

    // Octal opcode constants (op = ir[0:5]).
    localparam logic [5:0] OP_NA_LO  = 6'o20;
    localparam logic [5:0] OP_NA_HI  = 6'o57;
    localparam logic [5:0] OP_KA1_LO = 6'o60;
    localparam logic [5:0] OP_KA1_HI = 6'o67;
    localparam logic [5:0] OP_OU     = 6'o35;
    localparam logic [5:0] OP_IN     = 6'o36;
    localparam logic [5:0] OP_JS     = 6'o70;
    localparam logic [5:0] OP_KA2    = 6'o71;
    localparam logic [5:0] OP_C      = 6'o72;
    localparam logic [5:0] OP_S      = 6'o73;
    localparam logic [5:0] OP_J      = 6'o74;
    localparam logic [5:0] OP_L      = 6'o75;
    localparam logic [5:0] OP_G      = 6'o76;
    localparam logic [5:0] OP_BN     = 6'o77;

    // Map a 6-bit opcode onto its instruction group.
    function automatic grp_t op_group(input logic [5:0] op);
        grp_t g;
        g = GRP_NONE;
        if (op >= OP_NA_LO && op <= OP_NA_HI) begin
            g = GRP_NA;
        end else if (op >= OP_KA1_LO && op <= OP_KA1_HI) begin
            g = GRP_KA1;
        end else begin
            case (op)
                OP_JS:   g = GRP_JS;
                OP_KA2:  g = GRP_KA2;
                OP_C:    g = GRP_C;
                OP_S:    g = GRP_S;
                OP_J:    g = GRP_J;
                OP_L:    g = GRP_L;
                OP_G:    g = GRP_G;
                OP_BN:   g = GRP_BN;
                default: g = GRP_NONE;
            endcase
        end
        return g;
    endfunction

endpackage

// File: rtl/p_d_fifo.sv
// Circular prefetch queue of W-bit words with flush; pointers carry one wrap bit.
module p_d_fifo #(
    parameter int QDEPTH = 4,
    parameter int W      = 16
) (
    input  logic                      clk_sys,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push,
    input  logic                      pop,
    input  logic [0:W-1]              wdata,
    output logic [0:W-1]              rdata,
    output logic                      empty,
    output logic [$clog2(QDEPTH):0]   count
);

    localparam int AW = $clog2(QDEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [0:W-1]  mem_q [QDEPTH];
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (count == PW'(QDEPTH));
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update: flush empties the queue, otherwise advance on push/pop.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk_sys) begin
        // NOTE: the storage array is not reset; the pointers alone define which entries are valid.
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/p_d_pipe.sv
// Buffered P-D decoder: prefetch queue, one/two-word instruction assembly,
// group/field decode with legality check, registered record on valid/ready.
module p_d_pipe
    import p_d_pkg::*;
#(
    parameter int QDEPTH            = 4,
    parameter bit INOU_USER_ILLEGAL = 1'b1,
    parameter bit ARG_FETCH         = 1'b1
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:15] w,
    input  logic        flush,
    input  logic        q,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:15] ir,
    output logic [0:15] arg,
    output logic        has_arg,
    output logic [0:5]  op,
    output logic [0:2]  fa,
    output logic [0:2]  fb,
    output logic [0:2]  fc,
    output logic        fd,
    output grp_t        grp,
    output logic        xi
);

    localparam int CW = $clog2(QDEPTH) + 1;

    // Queue interface.
    logic [0:15]   head;
    logic          q_empty;
    logic [CW-1:0] q_count;
    logic          pop;

    // Registered record and FSM state.
    fsm_t        state_q, state_d;
    logic [0:15] ir_q, ir_d;
    logic [0:15] arg_q, arg_d;
    logic        has_arg_q, has_arg_d;
    grp_t        grp_q, grp_d;
    logic        xi_q, xi_d;

    // Decode of the word at the queue head.
    grp_t head_grp;
    logic head_needs_arg;
    logic head_xi;
    logic load;

    assign in_ready = (q_count != CW'(QDEPTH));

    p_d_fifo #(
        .QDEPTH (QDEPTH),
        .W      (16)
    ) u_fifo (
        .clk_sys (clk_sys),
        .rst     (rst),
        .flush   (flush),
        .push    (in_valid & in_ready),
        .pop     (pop),
        .wdata   (w),
        .rdata   (head),
        .empty   (q_empty),
        .count   (q_count)
    );

    // Group, argument need and legality of the head word; q is sampled here, at decode.
    always_comb begin
        head_grp       = op_group(head[0:5]);
        head_needs_arg = ARG_FETCH && (head_grp == GRP_NA) && (head[13:15] == 3'd0);
        head_xi        = 1'b0;
        if (head_grp == GRP_NONE)                                   head_xi = 1'b1;
        if (q && head_grp == GRP_S)                                 head_xi = 1'b1;
        if (q && head_grp == GRP_BN && head[7:9] >= 3'd5)           head_xi = 1'b1;
        if (INOU_USER_ILLEGAL && q &&
            (head[0:5] == OP_IN || head[0:5] == OP_OU))             head_xi = 1'b1;
        if (head_grp == GRP_C && head[10:12] != 3'd1)               head_xi = 1'b1;
    end

    // Assembly FSM: load ir, optionally fetch arg, hold the record until accepted.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        arg_d     = arg_q;
        has_arg_d = has_arg_q;
        grp_d     = grp_q;
        xi_d      = xi_q;
        pop       = 1'b0;
        load      = 1'b0;

        case (state_q)
            DEC_IDLE: begin
                if (!q_empty) load = 1'b1;
            end
            DEC_ARG: begin
                if (!q_empty) begin
                    pop       = 1'b1;
                    arg_d     = head;
                    has_arg_d = 1'b1;
                    state_d   = DEC_OUT;
                end
            end
            DEC_OUT: begin
                if (out_ready) begin
                    // Back-to-back: start the next instruction in the accept cycle.
                    if (!q_empty) load = 1'b1;
                    else          state_d = DEC_IDLE;
                end
            end
            default: state_d = DEC_IDLE;
        endcase

        if (load) begin
            pop       = 1'b1;
            ir_d      = head;
            arg_d     = '0;
            has_arg_d = 1'b0;
            grp_d     = head_grp;
            xi_d      = head_xi;
            state_d   = head_needs_arg ? DEC_ARG : DEC_OUT;
        end

        // Flush drops whatever is in flight, including a half-assembled instruction.
        if (flush) begin
            pop     = 1'b0;
            state_d = DEC_IDLE;
        end
    end

    // State and record registers; reset additionally clears the record.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q   <= DEC_IDLE;
            ir_q      <= '0;
            arg_q     <= '0;
            has_arg_q <= 1'b0;
            grp_q     <= GRP_NONE;
            xi_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            arg_q     <= arg_d;
            has_arg_q <= has_arg_d;
            grp_q     <= grp_d;
            xi_q      <= xi_d;
        end
    end

    assign out_valid = (state_q == DEC_OUT);
    assign ir        = ir_q;
    assign arg       = arg_q;
    assign has_arg   = has_arg_q;
    assign op        = ir_q[0:5];
    assign fd        = ir_q[6];
    assign fa        = ir_q[7:9];
    assign fb        = ir_q[10:12];
    assign fc        = ir_q[13:15];
    assign grp       = grp_q;
    assign xi        = xi_q;

endmodule

// File: tb/tb_p_d_pipe.sv
// Self-checking bench for p_d_pipe. Words use bit 0 = MSB: op=w[0:5], D=w[6],
// A=w[7:9], B=w[10:12], C=w[13:15]; hex words below are built from that layout.
// A second instance with INOU_USER_ILLEGAL=0 runs in lockstep on the same inputs.
module tb_p_d_pipe;
    import p_d_pkg::*;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [0:15] w;
    logic        flush;
    logic        q;
    logic        out_ready;

    logic        in_ready, out_valid, has_arg, fd, xi;
    logic [0:15] ir, arg;
    logic [0:5]  op;
    logic [0:2]  fa, fb, fc;
    grp_t        grp;

    logic        in_ready_b, out_valid_b, has_arg_b, fd_b, xi_b;
    logic [0:15] ir_b, arg_b;
    logic [0:5]  op_b;
    logic [0:2]  fa_b, fb_b, fc_b;
    grp_t        grp_b;

    int errors = 0;
    int checks = 0;

    always #5 clk_sys = ~clk_sys;

    p_d_pipe #(.QDEPTH(4), .INOU_USER_ILLEGAL(1'b1), .ARG_FETCH(1'b1)) dut (
        .clk_sys(clk_sys), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .w(w),
        .flush(flush), .q(q), .out_valid(out_valid), .out_ready(out_ready),
        .ir(ir), .arg(arg), .has_arg(has_arg), .op(op), .fa(fa), .fb(fb), .fc(fc),
        .fd(fd), .grp(grp), .xi(xi)
    );

    p_d_pipe #(.QDEPTH(4), .INOU_USER_ILLEGAL(1'b0), .ARG_FETCH(1'b1)) dut_b (
        .clk_sys(clk_sys), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .w(w),
        .flush(flush), .q(q), .out_valid(out_valid_b), .out_ready(out_ready),
        .ir(ir_b), .arg(arg_b), .has_arg(has_arg_b), .op(op_b), .fa(fa_b), .fb(fb_b), .fc(fc_b),
        .fd(fd_b), .grp(grp_b), .xi(xi_b)
    );

    typedef struct {
        logic [0:15] w;
        logic        q;
        grp_t        g;
        logic        xi;
        logic        xi_b;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_sys);
    endtask

    // Offer one word for a single edge (caller ensures in_ready).
    task automatic push(input logic [0:15] word);
        in_valid = 1'b1;
        w        = word;
        tick();
        in_valid = 1'b0;
        w        = '0;
    endtask

    // Bounded wait for out_valid; an expired budget counts as a failed check.
    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL %s timeout: out_valid=0 expected 1", name);
        end
    endtask

    // Accept the current record with a one-cycle out_ready pulse.
    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [0:15] wv;
        logic [0:15] burst [5];

        vecs[0]  = '{16'h8001, 1'b0, GRP_NA,   1'b0, 1'b0};  // 040 AW, C=1
        vecs[1]  = '{16'h4207, 1'b0, GRP_NA,   1'b0, 1'b0};  // 020, D=1, C=7
        vecs[2]  = '{16'hBC03, 1'b0, GRP_NA,   1'b0, 1'b0};  // 057 top of NA
        vecs[3]  = '{16'hC000, 1'b0, GRP_KA1,  1'b0, 1'b0};  // 060
        vecs[4]  = '{16'hDC00, 1'b0, GRP_KA1,  1'b0, 1'b0};  // 067
        vecs[5]  = '{16'hE000, 1'b0, GRP_JS,   1'b0, 1'b0};  // 070
        vecs[6]  = '{16'hE400, 1'b0, GRP_KA2,  1'b0, 1'b0};  // 071
        vecs[7]  = '{16'hE808, 1'b0, GRP_C,    1'b0, 1'b0};  // 072 B=1
        vecs[8]  = '{16'hE810, 1'b0, GRP_C,    1'b1, 1'b1};  // 072 B=2 reserved
        vecs[9]  = '{16'hEC00, 1'b1, GRP_S,    1'b1, 1'b1};  // 073 user mode
        vecs[10] = '{16'hEC00, 1'b0, GRP_S,    1'b0, 1'b0};  // 073 system mode
        vecs[11] = '{16'hF000, 1'b1, GRP_J,    1'b0, 1'b0};  // 074
        vecs[12] = '{16'hF400, 1'b1, GRP_L,    1'b0, 1'b0};  // 075
        vecs[13] = '{16'hF800, 1'b1, GRP_G,    1'b0, 1'b0};  // 076
        vecs[14] = '{16'hFD40, 1'b1, GRP_BN,   1'b1, 1'b1};  // 077 A=5 user
        vecs[15] = '{16'hFDC0, 1'b1, GRP_BN,   1'b1, 1'b1};  // 077 A=7 user
        vecs[16] = '{16'hFD00, 1'b1, GRP_BN,   1'b0, 1'b0};  // 077 A=4 user
        vecs[17] = '{16'hFD40, 1'b0, GRP_BN,   1'b0, 1'b0};  // 077 A=5 system
        vecs[18] = '{16'h7401, 1'b1, GRP_NA,   1'b1, 1'b0};  // 035 OU user
        vecs[19] = '{16'h7801, 1'b1, GRP_NA,   1'b1, 1'b0};  // 036 IN user
        vecs[20] = '{16'h7801, 1'b0, GRP_NA,   1'b0, 1'b0};  // 036 IN system
        vecs[21] = '{16'h7C01, 1'b1, GRP_NA,   1'b0, 1'b0};  // 037 neighbour of IN
        vecs[22] = '{16'h3C00, 1'b0, GRP_NONE, 1'b1, 1'b1};  // 017
        vecs[23] = '{16'h0000, 1'b1, GRP_NONE, 1'b1, 1'b1};  // 000

        rst = 1'b1; in_valid = 1'b0; w = '0; flush = 1'b0; q = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state.
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_ir_arg",    32'({ir, arg}), 32'd0);
        check("rst_grp",       32'(grp),       32'(GRP_NONE));
        check("rst_flags",     32'({has_arg, xi, fd, op, fa, fb, fc}), 32'd0);
        check("rst_b_ctrl",    32'({out_valid_b, in_ready_b, has_arg_b, xi_b, fd_b, grp_b, fa_b, fb_b, fc_b}),
              32'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 9'd0}));
        check("rst_b_rec",     32'({ir_b, arg_b}), 32'd0);
        check("rst_b_op",      32'(op_b), 32'd0);

        // Latency: push at edge N, out_valid visible after edge N+1.
        out_ready = 1'b1;
        push(16'h8001);
        check("lat_n1_valid", 32'(out_valid), 32'd0);
        tick();
        check("lat_n2_valid", 32'(out_valid), 32'd1);
        check("lat_op",       32'(op),        32'o40);
        check("lat_grp",      32'(grp),       32'(GRP_NA));
        check("lat_has_arg",  32'(has_arg),   32'd0);
        check("lat_xi",       32'(xi),        32'd0);
        tick();
        check("lat_drop",     32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Table of single-word instructions.
        for (int i = 0; i < 24; i++) begin
            q  = vecs[i].q;
            wv = vecs[i].w;
            push(wv);
            wait_valid($sformatf("vec%0d", i));
            check($sformatf("vec%0d_ir", i),   32'(ir),      32'(wv));
            check($sformatf("vec%0d_op", i),   32'(op),      32'(wv[0:5]));
            check($sformatf("vec%0d_fd", i),   32'(fd),      32'(wv[6]));
            check($sformatf("vec%0d_fa", i),   32'(fa),      32'(wv[7:9]));
            check($sformatf("vec%0d_fb", i),   32'(fb),      32'(wv[10:12]));
            check($sformatf("vec%0d_fc", i),   32'(fc),      32'(wv[13:15]));
            check($sformatf("vec%0d_grp", i),  32'(grp),     32'(vecs[i].g));
            check($sformatf("vec%0d_xi", i),   32'(xi),      32'(vecs[i].xi));
            check($sformatf("vec%0d_xi_b", i), 32'(xi_b),    32'(vecs[i].xi_b));
            check($sformatf("vec%0d_arg", i),  32'({has_arg, arg}), 32'd0);
            accept();
            check($sformatf("vec%0d_drop", i), 32'(out_valid), 32'd0);
        end
        q = 1'b0;

        // Two-word instruction with a gap before the argument word.
        push(16'h8000);
        check("arg_wait1", 32'(out_valid), 32'd0);
        tick();
        check("arg_wait2", 32'(out_valid), 32'd0);
        tick();
        check("arg_wait3", 32'(out_valid), 32'd0);
        push(16'h1234);
        wait_valid("arg");
        check("arg_ir",      32'(ir),      32'h8000);
        check("arg_arg",     32'(arg),     32'h1234);
        check("arg_has_arg", 32'(has_arg), 32'd1);
        check("arg_grp",     32'(grp),     32'(GRP_NA));
        check("arg_xi",      32'(xi),      32'd0);
        accept();

        // q change while the record is held must not alter xi.
        q = 1'b0;
        push(16'hEC00);
        wait_valid("qhold");
        q = 1'b1;
        tick(); tick();
        check("qhold_xi", 32'(xi), 32'd0);
        accept();
        q = 1'b0;

        // Backpressure: one word in ir plus four queued fills the block.
        for (int i = 0; i < 5; i++) burst[i] = 16'h8001 + 16'(i);
        for (int i = 0; i < 5; i++) begin
            push(burst[i]);
            if (i == 3) check("bp_ready_after4", 32'(in_ready), 32'd1);
        end
        check("bp_full",  32'(in_ready), 32'd0);
        in_valid = 1'b1;
        w        = 16'h8006;
        tick(); tick();
        in_valid = 1'b0;
        w        = '0;
        check("bp_still_full", 32'(in_ready), 32'd0);
        check("bp_stable_ir",  32'(ir),       32'(burst[0]));
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_drain%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_drain%0d_ir", i),    32'(ir),        32'(burst[i]));
            tick();
        end
        out_ready = 1'b0;
        check("bp_drained",   32'(out_valid), 32'd0);
        check("bp_ready_end", 32'(in_ready),  32'd1);

        // Flush in DEC_ARG with the argument queued and another word offered.
        push(16'h8000);
        push(16'h1234);
        in_valid = 1'b1;
        w        = 16'h5555;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        w        = '0;
        flush    = 1'b0;
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_ready", 32'(in_ready),  32'd1);
        tick(); tick(); tick();
        check("fl_empty", 32'(out_valid), 32'd0);
        push(16'h8001);
        wait_valid("fl_next");
        check("fl_next_ir",  32'(ir),               32'h8001);
        check("fl_next_arg", 32'({has_arg, arg}),   32'd0);
        check("fl_next_xi",  32'(xi),               32'd0);
        accept();

        // Undefined opcode, then reset while the record is held.
        push(16'h0000);
        wait_valid("none");
        check("none_grp", 32'(grp), 32'(GRP_NONE));
        check("none_xi",  32'(xi),  32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_valid", 32'(out_valid), 32'd0);
        check("rst2_ready", 32'(in_ready),  32'd1);
        check("rst2_rec",   32'({ir, arg}), 32'd0);
        check("rst2_flags", 32'({has_arg, xi, grp}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
